// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 constants and the fetch queue entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INS_NOP          = 32'h0000_0033;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO with flush, occupancy count and
//                same-cycle push/pop (no empty bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);
    // A pop frees the slot, so a push while full is legal only alongside a pop.
    assign w_push = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && w_full && !i_pop));

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : RV32 instruction fetch - PC, in-order imem requests, response
//                queue to decode, redirect flush with stale-response drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins,
    output logic [XLEN-1:0] ins_pc,
    input  logic            ins_ready
);

    localparam int c_CW = $clog2(QDEPTH + 1);
    localparam int c_OW = c_CW + 1;

    localparam logic [0:0] c_ST_FETCH = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            r_live;
    logic [XLEN-1:0] r_pc;
    logic [c_CW-1:0] r_outst;
    logic [c_CW-1:0] r_drop_cnt;

    logic [c_CW-1:0] w_drop_nxt;
    logic [c_CW-1:0] w_q_count;
    logic [c_CW-1:0] w_sh_count;
    logic [c_OW-1:0] w_occ;
    logic [XLEN-1:0] w_sh_pc;
    logic            w_gnt;
    logic            w_pop;
    logic            w_accept;
    fetch_entry_t    w_q_in;
    fetch_entry_t    w_q_head;
    logic            w_unused;

    assign w_unused = ^redirect_pc[1:0];

    assign w_pop     = ins_valid && ins_ready;
    assign w_occ     = c_OW'(r_outst) + c_OW'(w_q_count) - c_OW'(w_pop);
    // r_live keeps the request low while reset is asserted.
    assign imem_req  = r_live && !redirect_valid && (w_occ < c_OW'(QDEPTH));
    assign imem_addr = r_pc;
    assign w_gnt     = imem_req && imem_gnt;

    assign w_accept   = imem_rvalid && !redirect_valid && (r_state == c_ST_FETCH);
    // The response landing in the redirect cycle is already discarded.
    assign w_drop_nxt = r_outst - c_CW'(imem_rvalid);

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_drop_nxt != '0) ? c_ST_FLUSH : c_ST_FETCH;
        end else if (r_state == c_ST_FLUSH && imem_rvalid && r_drop_cnt == c_CW'(1)) begin
            w_state_nxt = c_ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_pc       <= {RESET_PC[XLEN-1:2], 2'b00};
            r_outst    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_live  <= 1'b1;
            r_outst <= r_outst + c_CW'(w_gnt) - c_CW'(imem_rvalid);
            if (redirect_valid) begin
                r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                r_drop_cnt <= w_drop_nxt;
            end else begin
                if (w_gnt) r_pc <= r_pc + 32'd4;
                if (imem_rvalid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - c_CW'(1);
            end
        end
    end

    // Shadow queue of issued addresses; every response pops it, stale or not.
    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (1'b0),
        .i_push  (w_gnt),
        .i_data  (r_pc),
        .i_pop   (imem_rvalid),
        .o_data  (w_sh_pc),
        .o_count (w_sh_count)
    );

    assign w_q_in = '{pc: w_sh_pc, ins: imem_rdata};

    fetch_fifo #(
        .DEPTH ($bits(fetch_entry_t) > 0 ? QDEPTH : QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_ins_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_accept),
        .i_data  (w_q_in),
        .i_pop   (w_pop),
        .o_data  (w_q_head),
        .o_count (w_q_count)
    );

    assign ins_valid = (w_q_count != '0);
    assign ins       = w_q_head.ins;
    assign ins_pc    = w_q_head.pc;

    a_rvalid_needs_outst: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && r_outst == '0));
    a_shadow_tracks_outst: assert property (@(posedge clk) disable iff (!rst_n)
        w_sh_count == r_outst);

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Directed self-checking bench for ifetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready = 1'b1;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic        w_valid;
    logic [31:0] w_ins;
    logic [31:0] w_ins_pc;
    logic        w_pend = 1'b0;
    logic [31:0] w_paddr = 32'h0;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int lat  = 1;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    pend_t pend[$];
    ent_t  dlv[$];
    ent_t  dlv_w[$];

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .ins_valid(w_valid), .ins(w_ins), .ins_pc(w_ins_pc), .ins_ready(1'b1)
    );

    // Fixed-latency in-order memory; returns addr ^ A5A5_0000.
    always @(posedge clk) begin
        if (rst_n && imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (pend.size() != 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ 32'hA5A5_0000;
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && ins_valid && ins_ready) dlv.push_back('{ins_pc, ins});
        if (rst_n && w_valid) dlv_w.push_back('{w_ins_pc, w_ins});
        w_pend  <= rst_n && w_req && w_gnt;
        w_paddr <= w_addr;
    end

    always @(negedge clk) begin
        w_rvalid = w_pend;
        w_rdata  = w_paddr ^ 32'hA5A5_0000;
    end

    task automatic do_reset(input logic g, input logic rdy, input int l);
        @(negedge clk);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = g; ins_ready = rdy; lat = l; w_gnt = 1'b0;
        #1;
        pend.delete(); dlv.delete(); dlv_w.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_ctl: req=%b valid=%b required 0/0", imem_req, ins_valid);
        end
        nvec++;
        if (ins !== 32'h0 || ins_pc !== 32'h0 || imem_addr !== 32'h0) begin
            nerr++; $display("FAIL reset_data: ins=%h pc=%h addr=%h required 0/0/0", ins, ins_pc, imem_addr);
        end
        nvec++;
        if (dut.r_outst !== 3'd0 || dut.r_drop_cnt !== 3'd0) begin
            nerr++; $display("FAIL reset_cnt: outst=%0d drop=%0d required 0/0", dut.r_outst, dut.r_drop_cnt);
        end
        nvec++;
        if (w_addr !== 32'hFFFF_FFF8 || w_req !== 1'b0) begin
            nerr++; $display("FAIL reset_pc_param: addr=%h req=%b required fffffff8/0", w_addr, w_req);
        end
    endtask

    task automatic test_seq();
        int g = -1;
        int v = -1;
        do_reset(1'b1, 1'b1, 1);
        for (int i = 0; i < 10 && g < 0; i++) begin
            @(negedge clk); #1;
            if (imem_req && imem_gnt) g = cyc;
        end
        nvec++;
        if (g < 0 || imem_addr !== 32'h0) begin
            nerr++; $display("FAIL seq_first_req: addr=%h granted=%0d required addr 00000000", imem_addr, g >= 0);
        end
        for (int i = 0; i < 10 && v < 0; i++) begin
            @(negedge clk); #1;
            if (ins_valid) v = cyc;
        end
        nvec++;
        if (v < 0 || g < 0 || v - g != 2) begin
            nerr++; $display("FAIL seq_latency: grant->valid=%0d required 2", v - g);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(4 * i) || ins !== (32'(4 * i) ^ 32'hA5A5_0000)) begin
                nerr++; $display("FAIL seq_stream[%0d]: valid=%b pc=%h ins=%h required 1/%h/%h",
                                 i, ins_valid, ins_pc, ins, 32'(4 * i), 32'(4 * i) ^ 32'hA5A5_0000);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset(1'b1, 1'b0, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (imem_req && imem_gnt) n++;
        end
        nvec++;
        if (n != 4 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL bp_grants: grants=%0d req=%b required 4/0", n, imem_req);
        end
        @(negedge clk);
        ins_ready = 1'b1;
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || ins_pc !== 32'h0) begin
            nerr++; $display("FAIL bp_resume: req=%b addr=%h head=%h required 1/00000010/00000000", imem_req, imem_addr, ins_pc);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            nvec++;
            if (ins_valid !== 1'b1 || ins_pc !== 32'(4 * i) || ins !== (32'(4 * i) ^ 32'hA5A5_0000)) begin
                nerr++; $display("FAIL bp_drain[%0d]: valid=%b pc=%h ins=%h required 1/%h", i, ins_valid, ins_pc, ins, 32'(4 * i));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (ins_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || dut.r_outst !== 3'd0) begin
            nerr++; $display("FAIL async_reset: valid=%b req=%b addr=%h outst=%0d required 0/0/0/0",
                             ins_valid, imem_req, imem_addr, dut.r_outst);
        end
    endtask

    task automatic test_redirect_inflight();
        int bad = 0;
        bit seen = 1'b0;
        do_reset(1'b0, 1'b1, 3);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            imem_gnt = (c == 1 || c == 2 || c == 6 || c == 7);
        end
        @(negedge clk);
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        nvec++;
        if (imem_req !== 1'b0 || dut.r_outst !== 3'd2) begin
            nerr++; $display("FAIL rd2_cycle: req=%b outst=%0d required 0/2", imem_req, dut.r_outst);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || ins_valid !== 1'b0 || dut.r_drop_cnt !== 3'd2) begin
            nerr++; $display("FAIL rd2_next: req=%b addr=%h valid=%b drop=%0d required 1/00000100/0/2",
                             imem_req, imem_addr, ins_valid, dut.r_drop_cnt);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            seen = ins_valid;
        end
        nvec++;
        if (!seen || ins_pc !== 32'h100 || ins !== (32'h100 ^ 32'hA5A5_0000)) begin
            nerr++; $display("FAIL rd2_target: valid=%b pc=%h ins=%h required 1/00000100/a5a50100", seen, ins_pc, ins);
        end
        foreach (dlv[k]) if (dlv[k].pc == 32'h8 || dlv[k].pc == 32'hC) bad++;
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL rd2_stale: stale deliveries=%0d required 0", bad);
        end
    endtask

    task automatic test_redirect_coincident();
        bit seen = 1'b0;
        do_reset(1'b1, 1'b1, 2);
        repeat (2) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        nvec++;
        if (dut.r_outst !== 3'd2) begin
            nerr++; $display("FAIL rdc_outst: outst=%0d required 2", dut.r_outst);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || dut.r_drop_cnt !== 3'd1 || ins_valid !== 1'b0) begin
            nerr++; $display("FAIL rdc_next: req=%b addr=%h drop=%0d valid=%b required 1/00000200/1/0",
                             imem_req, imem_addr, dut.r_drop_cnt, ins_valid);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            seen = ins_valid;
        end
        nvec++;
        if (!seen || ins_pc !== 32'h200 || ins !== (32'h200 ^ 32'hA5A5_0000) || dlv.size() != 0) begin
            nerr++; $display("FAIL rdc_target: valid=%b pc=%h ins=%h earlier=%0d required 1/00000200/a5a50200/0",
                             seen, ins_pc, ins, dlv.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp = 32'hFFFF_FFF8;
        logic [31:0] wpcs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        int ng = 0;
        do_reset(1'b0, 1'b1, 1);
        for (int i = 0; i < 40 && ng < 3; i++) begin
            @(negedge clk);
            w_gnt = (i == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
            #1;
            nvec++;
            if (w_addr !== exp || w_req !== 1'b1) begin
                nerr++; $display("FAIL wrap_addr[%0d]: addr=%h req=%b required %h/1", i, w_addr, w_req, exp);
            end
            if (w_req && w_gnt) begin
                exp = exp + 32'd4;
                ng++;
            end
        end
        @(negedge clk);
        w_gnt = 1'b0;
        for (int i = 0; i < 10 && dlv_w.size() < 3; i++) @(negedge clk);
        nvec++;
        if (ng != 3 || dlv_w.size() < 3) begin
            nerr++; $display("FAIL wrap_count: grants=%0d delivered=%0d required 3/3", ng, dlv_w.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                nvec++;
                if (dlv_w[k].pc !== wpcs[k] || dlv_w[k].ins !== (wpcs[k] ^ 32'hA5A5_0000)) begin
                    nerr++; $display("FAIL wrap_seq[%0d]: pc=%h ins=%h required %h", k, dlv_w[k].pc, dlv_w[k].ins, wpcs[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1, 1'b1, 2);
        repeat (3) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_pc = 32'h80;
        #1;
        nvec++;
        if (imem_req !== 1'b0) begin
            nerr++; $display("FAIL b2b_req: req=%b required 0", imem_req);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || dut.r_drop_cnt !== 3'd0 || ins_valid !== 1'b0) begin
            nerr++; $display("FAIL b2b_next: req=%b addr=%h drop=%0d valid=%b required 1/00000080/0/0",
                             imem_req, imem_addr, dut.r_drop_cnt, ins_valid);
        end
        dlv.delete();
        for (int i = 0; i < 20 && dlv.size() < 3; i++) @(negedge clk);
        nvec++;
        if (dlv.size() < 3) begin
            nerr++; $display("FAIL b2b_count: delivered=%0d required 3", dlv.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                nvec++;
                if (dlv[k].pc !== 32'(32'h80 + 4 * k) || dlv[k].ins !== (32'(32'h80 + 4 * k) ^ 32'hA5A5_0000)) begin
                    nerr++; $display("FAIL b2b_stream[%0d]: pc=%h ins=%h required %h", k, dlv[k].pc, dlv[k].ins, 32'(32'h80 + 4 * k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_backpressure();
        test_async_reset();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
